// File: rtl/mem_stage.sv
// Memory-access stage of a 5-stage RV32 pipeline. Accepts the EX/MEM payload,
// runs a req/gnt/rvalid handshake to data memory for loads and stores, formats
// byte/half/word lanes, and registers the MEM/WB payload as a one-cycle retire pulse.
module mem_stage #(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_ALUOutput,
  input  logic [31:0] i_rd2,
  input  logic [4:0]  i_write_reg,
  input  logic [2:0]  i_func3,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic        i_MemToReg,
  input  logic        i_RegWrite,
  input  logic        i_branch,
  input  logic [31:0] i_AddSum,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_write_reg,
  output logic        o_wb_RegWrite,
  output logic        o_branch_taken,
  output logic [31:0] o_branch_target,
  output logic        o_mem_fault
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DMEM_TIMEOUT - 1);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] rd2_q;
  logic [2:0]  func3_q;
  logic [4:0]  wreg_q;
  logic        we_q;
  logic        m2r_q;
  logic        rw_q;
  logic [7:0]  cnt;

  logic        in_fault;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        wb_rw_mem;

  // Select and extend the addressed byte/half of a read word.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'd0:    fmt_load = {{24{b[7]}}, b};
      3'd1:    fmt_load = {{16{h[15]}}, h};
      3'd4:    fmt_load = {24'b0, b};
      3'd5:    fmt_load = {16'b0, h};
      default: fmt_load = d;
    endcase
  endfunction

  // Misalignment / illegal-encoding detection on the incoming payload.
  always_comb begin
    in_fault = 1'b0;
    if (i_MemWrite) begin
      if (i_func3 > 3'd2) in_fault = 1'b1;
    end else if (i_func3 == 3'd3 || i_func3 == 3'd6 || i_func3 == 3'd7) begin
      in_fault = 1'b1;
    end
    if (i_func3[1:0] == 2'd1 && i_ALUOutput[0]) in_fault = 1'b1;
    if (i_func3[1:0] == 2'd2 && i_ALUOutput[1:0] != 2'b00) in_fault = 1'b1;
  end

  // Store lane steering from the latched access.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rd2_q;
    case (func3_q[1:0])
      2'd0: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{rd2_q[7:0]}};
      end
      2'd1: begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rd2_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign o_stall      = (state != IDLE);
  assign o_dmem_req   = (state == REQ);
  assign o_dmem_we    = o_dmem_req & we_q;
  assign o_dmem_addr  = o_dmem_req ? {addr_q[31:2], 2'b00} : 32'b0;
  assign o_dmem_be    = o_dmem_req ? st_be : 4'b0;
  assign o_dmem_wdata = (o_dmem_req && we_q) ? st_wdata : 32'b0;
  assign wb_rw_mem    = rw_q & (wreg_q != 5'd0) & ~we_q;

  // Access FSM plus retire register; o_wb_valid defaults low so it only pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      addr_q          <= 32'b0;
      rd2_q           <= 32'b0;
      func3_q         <= 3'b0;
      wreg_q          <= 5'b0;
      we_q            <= 1'b0;
      m2r_q           <= 1'b0;
      rw_q            <= 1'b0;
      o_wb_valid      <= 1'b0;
      o_wb_data       <= 32'b0;
      o_wb_write_reg  <= 5'b0;
      o_wb_RegWrite   <= 1'b0;
      o_branch_taken  <= 1'b0;
      o_branch_target <= 32'b0;
      o_mem_fault     <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            addr_q         <= i_ALUOutput;
            rd2_q          <= i_rd2;
            func3_q        <= i_func3;
            wreg_q         <= i_write_reg;
            we_q           <= i_MemWrite;
            m2r_q          <= i_MemToReg;
            rw_q           <= i_RegWrite;
            cnt            <= 8'd0;
            o_wb_write_reg <= i_write_reg;
            if (!i_MemRead && !i_MemWrite) begin
              o_wb_valid      <= 1'b1;
              o_wb_data       <= i_ALUOutput;
              o_wb_RegWrite   <= i_RegWrite & (i_write_reg != 5'd0);
              o_branch_taken  <= i_branch;
              o_branch_target <= i_AddSum;
              o_mem_fault     <= 1'b0;
            end else if (in_fault) begin
              o_wb_valid      <= 1'b1;
              o_wb_data       <= i_ALUOutput;
              o_wb_RegWrite   <= 1'b0;
              o_branch_taken  <= 1'b0;
              o_branch_target <= 32'b0;
              o_mem_fault     <= 1'b1;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (i_dmem_gnt) begin
            if (we_q || i_dmem_rvalid) begin
              state           <= IDLE;
              o_wb_valid      <= 1'b1;
              o_wb_data       <= (m2r_q && !we_q) ?
                                 fmt_load(func3_q, addr_q[1:0], i_dmem_rdata) : addr_q;
              o_wb_RegWrite   <= wb_rw_mem;
              o_branch_taken  <= 1'b0;
              o_branch_target <= 32'b0;
              o_mem_fault     <= 1'b0;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (i_dmem_rvalid) begin
            state           <= IDLE;
            o_wb_valid      <= 1'b1;
            o_wb_data       <= m2r_q ? fmt_load(func3_q, addr_q[1:0], i_dmem_rdata) : addr_q;
            o_wb_RegWrite   <= wb_rw_mem;
            o_branch_taken  <= 1'b0;
            o_branch_target <= 32'b0;
            o_mem_fault     <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state           <= IDLE;
            o_wb_valid      <= 1'b1;
            o_wb_data       <= addr_q;
            o_wb_RegWrite   <= 1'b0;
            o_branch_taken  <= 1'b0;
            o_branch_target <= 32'b0;
            o_mem_fault     <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32 pipeline. It sits directly downstream of the execute-stage ALU.
- It consumes the EX/MEM payload: ALU result/address, store data, destination register, control bits, and branch result/target.
- For loads and stores it runs a req/gnt/rvalid handshake to data memory, stalling upstream meanwhile. It formats byte/half/word accesses, then registers the MEM/WB payload.

Parameters:
DMEM_TIMEOUT, 255, max cycles waited in RESP for i_dmem_rvalid before a fault is raised; 8-bit counter, range 1..255.

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_valid  input  1  EX/MEM payload valid
i_ALUOutput  input  32  ALU result / effective address
i_rd2  input  32  store data (rs2)
i_write_reg  input  5  destination register
i_func3  input  3  access size/sign (RV32I load/store encoding)
i_MemRead  input  1  load
i_MemWrite  input  1  store
i_MemToReg  input  1  select load data for writeback
i_RegWrite  input  1  writeback enable
i_branch  input  1  branch taken (from ALU)
i_AddSum  input  32  branch target
o_stall  output  1  upstream must hold payload
o_dmem_req  output  1  memory request
o_dmem_we  output  1  1=write
o_dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
o_dmem_be  output  4  byte enables
o_dmem_wdata  output  32  lane-replicated store data
i_dmem_gnt  input  1  request accepted
i_dmem_rvalid  input  1  read data valid
i_dmem_rdata  input  32  read data
o_wb_valid  output  1  one-cycle retire pulse
o_wb_data  output  32  writeback value
o_wb_write_reg  output  5  writeback register
o_wb_RegWrite  output  1  writeback enable
o_branch_taken  output  1  registered redirect, valid with o_wb_valid
o_branch_target  output  32  registered redirect target
o_mem_fault  output  1  misaligned / illegal func3 / timeout, valid with o_wb_valid

Behaviour:
- Reset (async, i_reset=1):
  - State goes to IDLE; timeout counter is cleared.
  - All outputs go to 0, including o_stall, o_dmem_req, o_wb_valid, o_wb_RegWrite and o_mem_fault.
  - A reset during REQ/RESP abandons the access; a late rvalid/gnt arriving in IDLE is ignored.
- FSM states: IDLE, REQ, RESP. A payload is accepted only in IDLE with i_valid=1.
- o_stall = (state != IDLE), combinational from state. While it is high, inputs are ignored and upstream holds them.
- Non-memory op (MemRead=MemWrite=0):
  - Retires on the accept edge: latency 1, next state IDLE.
  - o_wb_data = i_ALUOutput.
  - o_branch_taken = i_branch and o_branch_target = i_AddSum; both are 0 for all memory ops.
- Memory op accepted in IDLE:
  - Latch address, size, data and control.
  - If the access is misaligned or func3 is illegal, retire next edge with o_mem_fault=1 and o_wb_RegWrite=0, with no memory request. Misaligned: H with addr[0]=1; W with addr[1:0]!=0. Illegal: load func3 3/6/7; store func3 >2.
  - Otherwise go to REQ.
- REQ:
  - o_dmem_req=1; addr/we/be/wdata are held stable until gnt.
  - gnt with a store: retire on that edge, go to IDLE.
  - gnt with a load and no rvalid: go to RESP.
  - gnt and rvalid in the same cycle with a load: retire directly, go to IDLE.
- RESP:
  - o_dmem_req=0; the counter increments each cycle.
  - rvalid: retire with formatted data, go to IDLE.
  - Counter reaches DMEM_TIMEOUT: retire with o_mem_fault=1 and RegWrite=0.
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{rd2[7:0]}}.
  - SH: be = addr[1]?1100:0011, wdata = {2{rd2[15:0]}}.
  - SW: be = 1111, wdata = rd2.
- Load formatting:
  - Byte is selected by addr[1:0]; half is selected by addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
  - o_wb_data = formatted data when MemToReg=1, else the latched ALUOutput.
- Retire register:
  - o_wb_valid pulses for exactly 1 cycle per accepted payload.
  - o_wb_RegWrite = RegWrite & (write_reg != 0) & ~fault. Stores force it to 0.
  - WB outputs hold their values between pulses.
- Back-to-back: the next payload is accepted on the first IDLE cycle after retire, so each memory op costs at least 2 cycles of acceptance.

Test Plan:
- ADD result 0x0000_0007, rd=5, RegWrite=1 -> next edge: o_wb_valid=1, o_wb_data=7, o_wb_write_reg=5, o_stall never asserted.
- SB rd2=0x1234_56AB, addr=0x103; gnt after 2 cycles -> o_dmem_addr=0x100, be=1000, wdata=0xABABABAB, req held 3 cycles, o_wb_RegWrite=0.
- LB addr=0x102, rdata=0x00_80_00_00, rvalid 3 cycles after gnt -> o_wb_data=0xFFFF_FF80. The same access as LBU -> 0x0000_0080. o_stall stays high until retire.
- LW addr=0x106 -> no req; o_mem_fault=1, o_wb_RegWrite=0 one cycle later. LH with gnt&rvalid in the same cycle, rdata=0x8001_0000, addr=0x102 -> 0xFFFF_8001.
- Branch: i_branch=1, i_AddSum=0x40 -> o_branch_taken=1, o_branch_target=0x40 with o_wb_valid. A load with no rvalid for 255 cycles -> o_mem_fault=1.
- Assert i_reset in RESP, then pulse rvalid after release -> state IDLE, o_wb_valid stays 0, o_stall=0.
